reg_wb_arbiter: RTL and testbench

- Shares the register file's single write port between two writeback producers: the ALU/EX pipeline (source A) and the load/store unit (source M).
- Each source has a one-entry holding buffer with a valid/ready handshake. The arbiter grants one buffer per cycle and drives the register file write port directly from that buffer.
- Also exports a pending-write mask for decode hazard checks and a saturating backpressure counter.

---
 rtl/reg_wb_arbiter_pkg.sv | 22 ++
 rtl/reg_wb_arbiter_if.sv | 47 ++++
 rtl/reg_wb_arbiter_slot.sv | 53 +++++
 rtl/reg_wb_arbiter.sv | 125 ++++++++++++
 tb/tb_reg_wb_arbiter.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/reg_wb_arbiter_pkg.sv
// ============================================================================
// Module : reg_wb_arbiter_pkg
// Brief  : Shared widths and writeback source encodings for the WB arbiter.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package reg_wb_arbiter_pkg;

    localparam int c_REG_ADDR_WIDTH = 5;
    localparam int c_REG_DATA_WIDTH = 32;
    localparam int c_REG_NUMBER     = 32;
    localparam int c_STALL_CNT_WIDTH = 16;

    typedef enum logic {
        WB_SRC_ALU = 1'b0,
        WB_SRC_LSU = 1'b1
    } wb_src_e;

endpackage

`default_nettype wire

// File: rtl/reg_wb_arbiter_if.sv
// ============================================================================
// Module : reg_wb_arbiter_if
// Brief  : Producer handshakes, register file write port and status outputs.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface reg_wb_arbiter_if
    import reg_wb_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = c_REG_ADDR_WIDTH,
    parameter int DATA_WIDTH = c_REG_DATA_WIDTH,
    parameter int REG_NUMBER = c_REG_NUMBER,
    parameter int CNT_WIDTH  = c_STALL_CNT_WIDTH
) ();

    logic                  i_AluWbValid;
    logic [ADDR_WIDTH-1:0] i_AluWbAddr;
    logic [DATA_WIDTH-1:0] i_AluWbData;
    logic                  o_AluWbReady;
    logic                  i_LsuWbValid;
    logic [ADDR_WIDTH-1:0] i_LsuWbAddr;
    logic [DATA_WIDTH-1:0] i_LsuWbData;
    logic                  o_LsuWbReady;
    logic                  o_RegWrEn;
    logic [ADDR_WIDTH-1:0] o_RegWrAddr;
    logic [DATA_WIDTH-1:0] o_RegWrData;
    logic [REG_NUMBER-1:0] o_PendMask;
    logic [CNT_WIDTH-1:0]  o_StallCnt;

    modport master (
        output i_AluWbValid, i_AluWbAddr, i_AluWbData,
        output i_LsuWbValid, i_LsuWbAddr, i_LsuWbData,
        input  o_AluWbReady, o_LsuWbReady,
        input  o_RegWrEn, o_RegWrAddr, o_RegWrData, o_PendMask, o_StallCnt
    );

    modport slave (
        input  i_AluWbValid, i_AluWbAddr, i_AluWbData,
        input  i_LsuWbValid, i_LsuWbAddr, i_LsuWbData,
        output o_AluWbReady, o_LsuWbReady,
        output o_RegWrEn, o_RegWrAddr, o_RegWrData, o_PendMask, o_StallCnt
    );

endinterface

`default_nettype wire

// File: rtl/reg_wb_arbiter_slot.sv
// ============================================================================
// Module : reg_wb_arbiter_slot
// Brief  : One-entry writeback holding buffer with ready generation and x0 drop.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module reg_wb_arbiter_slot #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
) (
    input  wire                   clk,
    input  wire                   reset,
    input  wire                   i_valid,
    input  wire  [ADDR_WIDTH-1:0] i_addr,
    input  wire  [DATA_WIDTH-1:0] i_data,
    input  wire                   i_grant,
    output logic                  o_ready,
    output logic                  o_full,
    output logic [ADDR_WIDTH-1:0] o_addr,
    output logic [DATA_WIDTH-1:0] o_data
);

    logic                  r_full;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  w_accept;

    // A granted slot drains at this edge, so it can take a new entry at the same time.
    assign o_ready  = !r_full || i_grant;
    assign w_accept = i_valid && o_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_full <= 1'b0;
            r_addr <= '0;
            r_data <= '0;
        end else if (w_accept && (i_addr != '0)) begin
            r_full <= 1'b1;
            r_addr <= i_addr;
            r_data <= i_data;
        end else if (i_grant) begin
            r_full <= 1'b0;
        end
    end

    assign o_full = r_full;
    assign o_addr = r_addr;
    assign o_data = r_data;

endmodule

`default_nettype wire

// File: rtl/reg_wb_arbiter.sv
// ============================================================================
// Module : reg_wb_arbiter
// Brief  : Arbitrates ALU and LSU writebacks onto the single register write port.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module reg_wb_arbiter
    import reg_wb_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = c_REG_ADDR_WIDTH,
    parameter int DATA_WIDTH = c_REG_DATA_WIDTH,
    parameter int REG_NUMBER = c_REG_NUMBER,
    parameter int CNT_WIDTH  = c_STALL_CNT_WIDTH
) (
    input wire               clk,
    input wire               reset,
    reg_wb_arbiter_if.slave  bus
);

    logic                  w_a_full, w_m_full;
    logic [ADDR_WIDTH-1:0] w_a_addr, w_m_addr;
    logic [DATA_WIDTH-1:0] w_a_data, w_m_data;
    logic                  w_grant_a, w_grant_m;
    logic                  w_grant_vld;
    logic                  w_contend;
    wb_src_e               w_grant_src;
    wb_src_e               r_rr_ptr;
    logic                  w_stall;
    logic [CNT_WIDTH-1:0]  r_stall_cnt;

    reg_wb_arbiter_slot #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_slot_a (
        .clk     (clk),
        .reset   (reset),
        .i_valid (bus.i_AluWbValid),
        .i_addr  (bus.i_AluWbAddr),
        .i_data  (bus.i_AluWbData),
        .i_grant (w_grant_a),
        .o_ready (bus.o_AluWbReady),
        .o_full  (w_a_full),
        .o_addr  (w_a_addr),
        .o_data  (w_a_data)
    );

    reg_wb_arbiter_slot #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_slot_m (
        .clk     (clk),
        .reset   (reset),
        .i_valid (bus.i_LsuWbValid),
        .i_addr  (bus.i_LsuWbAddr),
        .i_data  (bus.i_LsuWbData),
        .i_grant (w_grant_m),
        .o_ready (bus.o_LsuWbReady),
        .o_full  (w_m_full),
        .o_addr  (w_m_addr),
        .o_data  (w_m_data)
    );

    assign w_contend = w_a_full && w_m_full && (w_a_addr != w_m_addr);

    // Same-address collisions always favour the LSU so the younger ALU result lands last.
    always_comb begin
        w_grant_vld = 1'b0;
        w_grant_src = WB_SRC_ALU;
        if (w_a_full && w_m_full) begin
            w_grant_vld = 1'b1;
            w_grant_src = (w_a_addr == w_m_addr) ? WB_SRC_LSU : r_rr_ptr;
        end else if (w_a_full) begin
            w_grant_vld = 1'b1;
            w_grant_src = WB_SRC_ALU;
        end else if (w_m_full) begin
            w_grant_vld = 1'b1;
            w_grant_src = WB_SRC_LSU;
        end
    end

    assign w_grant_a = w_grant_vld && (w_grant_src == WB_SRC_ALU);
    assign w_grant_m = w_grant_vld && (w_grant_src == WB_SRC_LSU);

    always_comb begin
        bus.o_RegWrEn   = w_grant_vld;
        bus.o_RegWrAddr = '0;
        bus.o_RegWrData = '0;
        if (w_grant_a) begin
            bus.o_RegWrAddr = w_a_addr;
            bus.o_RegWrData = w_a_data;
        end else if (w_grant_m) begin
            bus.o_RegWrAddr = w_m_addr;
            bus.o_RegWrData = w_m_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rr_ptr <= WB_SRC_ALU;
        end else if (w_contend) begin
            r_rr_ptr <= (r_rr_ptr == WB_SRC_ALU) ? WB_SRC_LSU : WB_SRC_ALU;
        end
    end

    assign w_stall = (bus.i_AluWbValid && !bus.o_AluWbReady) ||
                     (bus.i_LsuWbValid && !bus.o_LsuWbReady);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stall_cnt <= '0;
        end else if (w_stall && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + CNT_WIDTH'(1);
        end
    end

    assign bus.o_StallCnt = r_stall_cnt;

    // Slots never hold x0, so bit 0 stays clear by construction.
    for (genvar r = 0; r < REG_NUMBER; r++) begin : g_mask
        if (r == 0) begin : g_zero
            assign bus.o_PendMask[r] = 1'b0;
        end else begin : g_reg
            assign bus.o_PendMask[r] = (w_a_full && (w_a_addr == ADDR_WIDTH'(r))) ||
                                       (w_m_full && (w_m_addr == ADDR_WIDTH'(r)));
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_reg_wb_arbiter.sv
// ============================================================================
// Module : tb_reg_wb_arbiter
// Brief  : Directed and random checks of reg_wb_arbiter against a reference model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_reg_wb_arbiter;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    reg_wb_arbiter_if bus ();

    reg_wb_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    // Reference model: two pending entries, a fairness pointer, a counter, a register file.
    logic        mfull [2];
    logic [4:0]  maddr [2];
    logic [31:0] mdata [2];
    int          mrr;
    logic [15:0] mcnt;
    logic [31:0] mrf [32];
    logic [31:0] dut_rf [32];

    logic        obs_rdy_a, obs_rdy_m, obs_wen;
    logic [4:0]  obs_waddr;
    logic [31:0] obs_wdata, obs_mask;
    logic [15:0] obs_cnt;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mfull[0] = 1'b0; mfull[1] = 1'b0;
        maddr[0] = '0;   maddr[1] = '0;
        mdata[0] = '0;   mdata[1] = '0;
        mrr = 0;
        mcnt = '0;
    endtask

    // One clock cycle: drive inputs, check outputs against the model, advance the model.
    task automatic cycle(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                         input logic mv, input logic [4:0] ma, input logic [31:0] md);
        int          g;
        logic        rdy [2];
        logic        v [2];
        logic [4:0]  ia [2];
        logic [31:0] id [2];
        logic [31:0] emask;
        @(negedge clk);
        bus.i_AluWbValid = av; bus.i_AluWbAddr = aa; bus.i_AluWbData = ad;
        bus.i_LsuWbValid = mv; bus.i_LsuWbAddr = ma; bus.i_LsuWbData = md;
        #1;
        v[0] = av; ia[0] = aa; id[0] = ad;
        v[1] = mv; ia[1] = ma; id[1] = md;
        g = -1;
        if (mfull[0] && mfull[1]) g = (maddr[0] == maddr[1]) ? 1 : mrr;
        else if (mfull[0])        g = 0;
        else if (mfull[1])        g = 1;
        emask = '0;
        for (int i = 0; i < 2; i++) begin
            rdy[i] = !mfull[i] || (g == i);
            if (mfull[i]) emask = emask | (32'd1 << maddr[i]);
        end
        obs_rdy_a = bus.o_AluWbReady; obs_rdy_m = bus.o_LsuWbReady;
        obs_wen = bus.o_RegWrEn; obs_waddr = bus.o_RegWrAddr; obs_wdata = bus.o_RegWrData;
        obs_mask = bus.o_PendMask; obs_cnt = bus.o_StallCnt;
        chk("ready_a", obs_rdy_a, rdy[0]);
        chk("ready_m", obs_rdy_m, rdy[1]);
        chk("wr_en", obs_wen, g >= 0);
        chk("wr_addr", obs_waddr, (g >= 0) ? maddr[g] : 5'd0);
        chk("wr_data", obs_wdata, (g >= 0) ? mdata[g] : 32'd0);
        chk("pend_mask", obs_mask, emask);
        chk("stall_cnt", obs_cnt, mcnt);
        if (obs_wen) dut_rf[obs_waddr] = obs_wdata;
        // advance the model to the next edge
        if (((v[0] && !rdy[0]) || (v[1] && !rdy[1])) && mcnt != 16'hFFFF) mcnt = mcnt + 16'd1;
        if (mfull[0] && mfull[1] && maddr[0] != maddr[1]) mrr = 1 - mrr;
        if (g >= 0) begin
            mrf[maddr[g]] = mdata[g];
            mfull[g] = 1'b0;
        end
        for (int i = 0; i < 2; i++) begin
            if (v[i] && rdy[i] && ia[i] != 5'd0) begin
                mfull[i] = 1'b1; maddr[i] = ia[i]; mdata[i] = id[i];
            end
        end
    endtask

    task automatic idle();
        cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 2; k++) begin
            bus.i_AluWbValid = 1'($urandom); bus.i_AluWbAddr = 5'($urandom); bus.i_AluWbData = $urandom;
            bus.i_LsuWbValid = 1'($urandom); bus.i_LsuWbAddr = 5'($urandom); bus.i_LsuWbData = $urandom;
            #1;
            chk("rst_wr_en", bus.o_RegWrEn, 1'b0);
            chk("rst_wr_addr", bus.o_RegWrAddr, 5'd0);
            chk("rst_wr_data", bus.o_RegWrData, 32'd0);
            chk("rst_mask", bus.o_PendMask, 32'd0);
            chk("rst_cnt", bus.o_StallCnt, 16'd0);
            chk("rst_ready_a", bus.o_AluWbReady, 1'b1);
            chk("rst_ready_m", bus.o_LsuWbReady, 1'b1);
            @(negedge clk);
        end
        model_reset();
        reset = 1'b1;
        bus.i_AluWbValid = 1'b0;
        bus.i_LsuWbValid = 1'b0;
    endtask

    // Both sources keep offering; a stalled source holds its transfer.
    task automatic dual_traffic(input int n);
        logic [4:0]  aa, ma;
        logic [31:0] ad, md;
        aa = 5'd1; ma = 5'd16; ad = $urandom; md = $urandom;
        for (int k = 0; k < n; k++) begin
            cycle(1'b1, aa, ad, 1'b1, ma, md);
            if (obs_rdy_a) begin aa = 5'(1 + (aa % 15)); ad = $urandom; end
            if (obs_rdy_m) begin ma = 5'(16 + ((ma - 15) % 16)); md = $urandom; end
        end
    endtask

    initial begin
        logic        av, mv, a_hold, m_hold;
        logic [4:0]  aa, ma;
        logic [31:0] ad, md;
        logic [15:0] cnt_before;
        for (int i = 0; i < 32; i++) begin mrf[i] = '0; dut_rf[i] = '0; end
        model_reset();
        bus.i_AluWbValid = 1'b0; bus.i_AluWbAddr = '0; bus.i_AluWbData = '0;
        bus.i_LsuWbValid = 1'b0; bus.i_LsuWbAddr = '0; bus.i_LsuWbData = '0;
        do_reset();

        // single ALU write
        cycle(1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 32'd0);
        idle();
        chk("a5_en", obs_wen, 1'b1);
        chk("a5_addr", obs_waddr, 5'd5);
        chk("a5_data", obs_wdata, 32'h1234);
        chk("a5_mask", obs_mask[5], 1'b1);
        idle();

        // contention: A first, then M first on the repeat
        cnt_before = mcnt;
        cycle(1'b1, 5'd3, 32'hAAAA, 1'b1, 5'd7, 32'hBBBB);
        idle(); chk("pair1_first", obs_waddr, 5'd3);
        idle(); chk("pair1_second", obs_waddr, 5'd7);
        chk("pair1_cnt", obs_cnt, cnt_before);
        cycle(1'b1, 5'd3, 32'hAAAA, 1'b1, 5'd7, 32'hBBBB);
        idle(); chk("pair2_first", obs_waddr, 5'd7);
        idle(); chk("pair2_second", obs_waddr, 5'd3);

        // same address: LSU lands first
        cycle(1'b1, 5'd9, 32'h1, 1'b1, 5'd9, 32'h2);
        idle(); chk("same_first", obs_wdata, 32'h2);
        idle(); chk("same_second", obs_wdata, 32'h1);
        idle(); chk("same_rf9", dut_rf[9], 32'h1);

        // sustained backpressure
        dual_traffic(6);
        idle(); idle(); idle();

        // x0 transfer is accepted and dropped
        cycle(1'b1, 5'd0, 32'hDEAD, 1'b0, 5'd0, 32'd0);
        chk("x0_ready", obs_rdy_a, 1'b1);
        idle();
        chk("x0_wr_en", obs_wen, 1'b0);
        chk("x0_mask", obs_mask, 32'd0);

        // random traffic honouring the hold rule
        av = 0; mv = 0; aa = 0; ma = 0; ad = 0; md = 0;
        a_hold = 0; m_hold = 0;
        for (int k = 0; k < 3000; k++) begin
            if (!a_hold) begin av = ($urandom_range(0, 3) != 0); aa = 5'($urandom_range(0, 7)); ad = $urandom; end
            if (!m_hold) begin mv = ($urandom_range(0, 3) != 0); ma = 5'($urandom_range(0, 7)); md = $urandom; end
            cycle(av, aa, ad, mv, ma, md);
            a_hold = av && !obs_rdy_a;
            m_hold = mv && !obs_rdy_m;
        end
        idle(); idle(); idle();

        // reset with both slots full discards them and restores A priority
        cycle(1'b1, 5'd11, 32'h1111, 1'b1, 5'd12, 32'h2222);
        do_reset();
        idle(); chk("rstmid_en", obs_wen, 1'b0);
        chk("rstmid_mask", obs_mask, 32'd0);
        idle(); chk("rstmid_en2", obs_wen, 1'b0);
        cycle(1'b1, 5'd13, 32'h3333, 1'b1, 5'd14, 32'h4444);
        idle(); chk("rstmid_rr", obs_waddr, 5'd13);
        idle(); idle();

        // drive the stall counter into saturation
        dual_traffic(65600);
        chk("sat_cnt", obs_cnt, 16'hFFFF);
        dual_traffic(3);
        chk("sat_hold", obs_cnt, 16'hFFFF);
        idle(); idle(); idle();

        for (int i = 1; i < 32; i++) chk($sformatf("rf_%0d", i), dut_rf[i], mrf[i]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
